// File: rtl/mdu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_core_pkg
// Description : Opcode and state encodings shared by the multiply/divide unit,
//               plus small helpers that classify opcodes by latency class.
//               MADD/MSUB are only classified as multiply-class when
//               MDU_MADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_core_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MSUB  = 4'd8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    // Opcodes that take the multiply latency
    function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
`else
        return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
    endfunction

    // Opcodes that take the divide latency
    function automatic logic is_div_class(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_calc
// Description : Combinational arithmetic for the multiply/divide unit.
//               Produces the next {HI,LO} pair and a divide-by-zero flag.
//               MADD/MSUB accumulate into {HI,LO} when MDU_MADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_calc
    import mdu_core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi_n,
    output logic [WIDTH-1:0] o_lo_n,
    output logic             o_div_zero
);

    localparam int W2 = 2 * WIDTH;

    logic signed [W2-1:0] w_prod_s;
    logic        [W2-1:0] w_prod_u;
    logic        [WIDTH-1:0] w_b_safe;
    logic                 w_b_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic        [WIDTH-1:0] w_a_mag;
    logic        [WIDTH-1:0] w_b_mag;
    logic        [WIDTH-1:0] w_sq_mag;
    logic        [WIDTH-1:0] w_sr_mag;
    logic        [WIDTH-1:0] w_sq;
    logic        [WIDTH-1:0] w_sr;
    logic        [WIDTH-1:0] w_uq;
    logic        [WIDTH-1:0] w_ur;

    // Full-width products; operands widened first so nothing is truncated
    assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) *
                      $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
    assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // A zero divisor is replaced by 1 so the dividers never see X; the
    // result is discarded anyway through o_div_zero.
    assign w_b_zero = (i_b == '0);
    assign w_b_safe = w_b_zero ? WIDTH'(1) : i_b;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend's sign. The -2^(W-1)/-1 overflow falls
    // out naturally as quotient = A, remainder = 0.
    assign w_a_neg  = i_a[WIDTH-1];
    assign w_b_neg  = w_b_safe[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -w_b_safe : w_b_safe;
    assign w_sq_mag = w_a_mag / w_b_mag;
    assign w_sr_mag = w_a_mag % w_b_mag;
    assign w_sq     = (w_a_neg ^ w_b_neg) ? -w_sq_mag : w_sq_mag;
    assign w_sr     = w_a_neg ? -w_sr_mag : w_sr_mag;

    assign w_uq     = i_a / w_b_safe;
    assign w_ur     = i_a % w_b_safe;

    assign o_div_zero = w_b_zero && is_div_class(i_op);

`ifdef MDU_MADD_EN
    logic [W2-1:0] w_acc;
    assign w_acc = {i_hi, i_lo};
`endif

    // Select the result pair for the requested operation
    always_comb begin
        {o_hi_n, o_lo_n} = {i_hi, i_lo};
        case (i_op)
            MDU_MULT:  {o_hi_n, o_lo_n} = w_prod_s;
            MDU_MULTU: {o_hi_n, o_lo_n} = w_prod_u;
            MDU_DIV:   {o_hi_n, o_lo_n} = {w_sr, w_sq};
            MDU_DIVU:  {o_hi_n, o_lo_n} = {w_ur, w_uq};
`ifdef MDU_MADD_EN
            MDU_MADD:  {o_hi_n, o_lo_n} = w_acc + w_prod_s;
            MDU_MSUB:  {o_hi_n, o_lo_n} = w_acc - w_prod_s;
`endif
            default:   {o_hi_n, o_lo_n} = {i_hi, i_lo};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_core
// Description : Multi-cycle multiply/divide unit owning the HI/LO pair.
//               Results are computed at issue, held in hi_n/lo_n, and
//               committed when the latency counter expires. busy is high for
//               exactly MULT_CYCLES or DIV_CYCLES cycles.
//               Optional MADD/MSUB support is enabled by MDU_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_core
    import mdu_core_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDUOp,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi_n;
    logic [WIDTH-1:0] r_lo_n;
    logic             r_dz;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_capture;
    logic [WIDTH-1:0] w_hi_calc;
    logic [WIDTH-1:0] w_lo_calc;
    logic             w_dz_calc;

    // HI/LO cannot change while RUN (every start is ignored), so computing
    // MADD/MSUB against the issue-time HI/LO equals using the completion-time
    // value.
    mdu_calc #(
        .WIDTH      (WIDTH)
    ) u_calc (
        .i_a        (A),
        .i_b        (B),
        .i_op       (MDUOp),
        .i_hi       (r_hi),
        .i_lo       (r_lo),
        .o_hi_n     (w_hi_calc),
        .o_lo_n     (w_lo_calc),
        .o_div_zero (w_dz_calc)
    );

    // Next-state, counter and HI/LO update decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult_class(MDUOp)) begin
                        w_capture   = 1'b1;
                        w_cnt_nxt   = C_MULT_LOAD;
                        w_state_nxt = ST_RUN;
                    end else if (is_div_class(MDUOp)) begin
                        w_capture   = 1'b1;
                        w_cnt_nxt   = C_DIV_LOAD;
                        w_state_nxt = ST_RUN;
                    end else if (MDUOp == MDU_MTHI) begin
                        w_hi_nxt    = A;
                    end else if (MDUOp == MDU_MTLO) begin
                        w_lo_nxt    = A;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    if (!r_dz) begin
                        w_hi_nxt = r_hi_n;
                        w_lo_nxt = r_lo_n;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counter, HI/LO and pending-result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_hi_n  <= '0;
            r_lo_n  <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_capture) begin
                r_hi_n <= w_hi_calc;
                r_lo_n <= w_lo_calc;
                r_dz   <= w_dz_calc;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_core
// Description : Self-checking bench for mdu_core. Expected {HI,LO} pairs are
//               queued at issue and popped when busy falls. MADD/MSUB checks
//               follow MDU_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_core;
    import mdu_core_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          errors;
    int          checks;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_core #(
        .WIDTH       (32),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the {HI,LO} result
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = sa * sb;
            MDU_MULTU: res = {32'd0, a} * {32'd0, b};
            MDU_DIV:   if (b != 32'd0) begin
                           q   = sa / sb;
                           r   = sa % sb;
                           res = {r[31:0], q[31:0]};
                       end
            MDU_DIVU:  if (b != 32'd0) res = {a % b, a / b};
            MDU_MADD:  res = {hi, lo} + (sa * sb);
            MDU_MSUB:  res = {hi, lo} - (sa * sb);
            default:   res = {hi, lo};
        endcase
        return res;
    endfunction

    function automatic int lat(input logic [3:0] op);
        return is_div_class(op) ? DC : MC;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MDUOp = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles (sampled on negedges) until busy drops; bounded
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
    endtask

    task automatic test_mult();
        logic [3:0]  ops[2] = '{MDU_MULT, MDU_MULTU};
        logic [63:0] exps[2] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA};
        logic [63:0] e;
        int n;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(exps[i]);
            issue(ops[i], 32'hFFFFFFFE, 32'd3);
            wait_idle(n);
            e = sb_q.pop_front();
            {m_hi, m_lo} = e;
            checks++; if (n != MC) begin errors++; $display("FAIL mult_latency[%0d] got=%0d exp=%0d", i, n, MC); end
            checks++; if (HI !== e[63:32]) begin errors++; $display("FAIL mult_hi[%0d] got=%h exp=%h", i, HI, e[63:32]); end
            checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL mult_lo[%0d] got=%h exp=%h", i, LO, e[31:0]); end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops[2] = '{MDU_DIV, MDU_DIVU};
        logic [31:0] as[2]  = '{32'hFFFFFFF9, 32'd7};
        logic [63:0] exps[2] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003};
        logic [63:0] e;
        int n;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(exps[i]);
            issue(ops[i], as[i], 32'd2);
            wait_idle(n);
            e = sb_q.pop_front();
            {m_hi, m_lo} = e;
            checks++; if (n != DC) begin errors++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, n, DC); end
            checks++; if (HI !== e[63:32]) begin errors++; $display("FAIL div_hi[%0d] got=%h exp=%h", i, HI, e[63:32]); end
            checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL div_lo[%0d] got=%h exp=%h", i, LO, e[31:0]); end
        end
    endtask

    task automatic test_mt();
        @(negedge clk);
        MDUOp = MDU_MTHI; A = 32'h12345678; start = 1'b1;
        @(negedge clk);
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi got=%h exp=12345678", HI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        MDUOp = MDU_MTLO; A = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;
        checks++; if (LO !== m_lo) begin errors++; $display("FAIL mtlo got=%h exp=%h", LO, m_lo); end
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL mtlo_hi_kept got=%h exp=%h", HI, m_hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
    endtask

    task automatic test_divzero();
        logic [3:0] ops[2] = '{MDU_DIV, MDU_DIVU};
        logic [63:0] e;
        int n;
        issue(MDU_MTHI, 32'hAA, 32'd0);
        issue(MDU_MTLO, 32'hBB, 32'd0);
        m_hi = 32'hAA;
        m_lo = 32'hBB;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back({32'hAA, 32'hBB});
            issue(ops[i], 32'd1234, 32'd0);
            wait_idle(n);
            e = sb_q.pop_front();
            checks++; if (n != DC) begin errors++; $display("FAIL divzero_latency[%0d] got=%0d exp=%0d", i, n, DC); end
            checks++; if (HI !== e[63:32]) begin errors++; $display("FAIL divzero_hi[%0d] got=%h exp=%h", i, HI, e[63:32]); end
            checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL divzero_lo[%0d] got=%h exp=%h", i, LO, e[31:0]); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops[8];
        logic [31:0] as[8];
        logic [31:0] bs[8];
        logic [63:0] e;
        int n;
        ops[0] = MDU_DIV;  as[0] = 32'h80000000; bs[0] = 32'hFFFFFFFF;
        ops[1] = MDU_DIV;  as[1] = 32'd5;        bs[1] = 32'hFFFFFFFD;
        ops[2] = MDU_DIVU; as[2] = 32'hFFFFFFFF; bs[2] = 32'd1;
        ops[3] = MDU_MULT; as[3] = 32'h80000000; bs[3] = 32'h80000000;
        for (int i = 4; i < 8; i++) begin
            ops[i] = 4'($urandom_range(1, 4));
            as[i]  = $urandom;
            bs[i]  = $urandom | 32'd1;
        end
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(model(ops[i], as[i], bs[i], m_hi, m_lo));
            issue(ops[i], as[i], bs[i]);
            wait_idle(n);
            e = sb_q.pop_front();
            {m_hi, m_lo} = e;
            checks++; if (n != lat(ops[i])) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, n, lat(ops[i])); end
            checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL rand_hilo[%0d] op=%0d got=%h exp=%h", i, ops[i], {HI, LO}, e); end
        end
    endtask

    task automatic test_ignore_busy();
        logic [63:0] e;
        int n;
        sb_q.push_back(model(MDU_DIV, 32'd100, 32'd7, m_hi, m_lo));
        issue(MDU_DIV, 32'd100, 32'd7);
        MDUOp = MDU_MTHI; A = 32'hDEAD0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL busy_mthi_ignored got=%h exp=%h", HI, m_hi); end
        wait_idle(n);
        n++;
        e = sb_q.pop_front();
        {m_hi, m_lo} = e;
        checks++; if (n != DC) begin errors++; $display("FAIL busy_latency got=%0d exp=%0d", n, DC); end
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL busy_result got=%h exp=%h", {HI, LO}, e); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        sb_q.push_back(model(MDU_MULT, 32'd7, 32'hFFFFFFFD, m_hi, m_lo));
        issue(MDU_MULT, 32'd7, 32'hFFFFFFFD);
        repeat (MC - 1) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_last_busy got=%b exp=1", busy); end
        MDUOp = MDU_MTHI; A = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        e = sb_q.pop_front();
        {m_hi, m_lo} = e;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_busy got=%b exp=0", busy); end
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL b2b_edge_start_ignored got=%h exp=%h", {HI, LO}, e); end
        @(negedge clk);
        start = 1'b0;
        m_hi = 32'hCAFEF00D;
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL b2b_accept_next got=%h exp=%h", HI, m_hi); end
    endtask

    task automatic test_noop();
        logic [3:0] ops[3] = '{4'd0, 4'd9, 4'd15};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'h11111111, 32'h22222222);
            checks++; if (busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo}) begin
                errors++; $display("FAIL noop[%0d] busy=%b hilo=%h exp_busy=0 exp_hilo=%h", i, busy, {HI, LO}, {m_hi, m_lo});
            end
        end
    endtask

    task automatic test_madd();
`ifdef MDU_MADD_EN
        logic [3:0]  ops[2] = '{MDU_MADD, MDU_MSUB};
        logic [63:0] exps[2] = '{64'h00000001_00000000, 64'h00000000_FFFFFFFF};
        logic [63:0] e;
        int n;
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(exps[i]);
            issue(ops[i], 32'd1, 32'd1);
            wait_idle(n);
            e = sb_q.pop_front();
            checks++; if (n != MC) begin errors++; $display("FAIL madd_latency[%0d] got=%0d exp=%0d", i, n, MC); end
            checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL madd_hilo[%0d] got=%h exp=%h", i, {HI, LO}, e); end
        end
        m_hi = 32'd0;
        m_lo = 32'hFFFFFFFF;
        sb_q.push_back(model(MDU_MSUB, 32'hFFFFFFF0, 32'd3, m_hi, m_lo));
        issue(MDU_MSUB, 32'hFFFFFFF0, 32'd3);
        wait_idle(n);
        e = sb_q.pop_front();
        {m_hi, m_lo} = e;
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL msub_neg got=%h exp=%h", {HI, LO}, e); end
`else
        issue(MDU_MADD, 32'd1, 32'd1);
        checks++; if (busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL madd_disabled busy=%b hilo=%h exp_busy=0 exp_hilo=%h", busy, {HI, LO}, {m_hi, m_lo});
        end
        issue(MDU_MSUB, 32'd1, 32'd1);
        checks++; if (busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL msub_disabled busy=%b hilo=%h exp_busy=0 exp_hilo=%h", busy, {HI, LO}, {m_hi, m_lo});
        end
`endif
    endtask

    task automatic test_abort();
        issue(MDU_MULT, 32'd5, 32'd6);
        @(negedge clk);
        MDUOp = MDU_MTLO; A = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (LO !== m_lo) begin errors++; $display("FAIL abort_mtlo_ignored got=%h exp=%h", LO, m_lo); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL abort_reset busy=%b hi=%h lo=%h exp=0/0/0", busy, HI, LO);
        end
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL abort_no_writeback busy=%b hi=%h lo=%h exp=0/0/0", busy, HI, LO);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        start  = 1'b0;
        A      = 32'd0;
        B      = 32'd0;
        MDUOp  = 4'd0;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_divzero();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_noop();
        test_madd();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multi-cycle multiply/divide unit; parametrised successor of the single-cycle ALU.
- Sits in the EX stage beside the ALU and owns the HI/LO register pair.
- The pipeline controller stalls dependent MDU instructions while `busy` is high.
- Adds a sequential latency model, signed/unsigned modes and HI/LO writes, none of which the combinational ALU has.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for multiply ops (>=1).
- DIV_CYCLES, 10, busy cycles for divide ops (>=1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- MDUOp  in  4  operation code (package constants).
- start  in  1  one-cycle qualifier; MDUOp/A/B are sampled on this edge.
- busy  out  1  operation in flight.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, busy=0, counter=0, pending result discarded.
  - Reset wins over every other input in the same cycle, including mid-operation.
- Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO; any other code with start=1 is a no-op.
- States: IDLE, RUN.
- IDLE, start=1, mult/div op:
  - Latch the full result into internal registers hi_n/lo_n.
  - Load counter = latency-1; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, MTHI: HI<=A at that edge, busy stays 0. MTLO: LO<=A likewise. A single-cycle write.
- RUN: counter decrements each edge.
  - At the edge where counter==0: HI<=hi_n, LO<=lo_n, busy<=0, return to IDLE.
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- HI/LO keep their old values throughout RUN; new values are visible in the first cycle after busy falls.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO. The controller must stall; the bench asserts no state change.
- MULT: signed 2*WIDTH product, HI=upper half, LO=lower half. MULTU: unsigned product, same split.
- DIV: LO=quotient, HI=remainder.
  - Signed, truncation toward zero; remainder takes the dividend's sign.
  - Overflow case (-2^(WIDTH-1) / -1): LO=A, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV/DIVU, B=0): full latency is still consumed; HI and LO are left unchanged at completion.
- A start in the same cycle that busy falls (counter==0 edge): ignored, since busy=1 is sampled that cycle; accepted next cycle.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD and MSUB (signed) using MULT_CYCLES latency.
  - Completion writes {HI,LO} <= {HI,LO} ± A*B, modulo 2^(2*WIDTH).
  - The {HI,LO} value used is the one current at the completion edge.
- Undefined: those opcodes are no-ops, like any other unknown code.

Decomposition:
- Shared package/header `const.v` gains MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MADD=7, MDU_MSUB=8, plus the state encodings IDLE=0, RUN=1.
- One natural sub-module: `mdu_calc`.
  - Combinational; computes {hi_n, lo_n} and a div-by-zero flag from A, B, MDUOp, HI, LO.
  - Keeps the mdu_core FSM/counter free of arithmetic.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3, start 1 cycle -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated on each edge, busy never asserts.
- With HI=0xAA, LO=0xBB, DIV B=0 -> busy 10 cycles, HI=0xAA, LO=0xBB afterwards.
- MULT in flight, pulse start with MTLO A=0x1 at cycle 2, then assert reset at cycle 3 -> MTLO has no effect; after reset HI=LO=0, busy=0 next cycle, no late writeback.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 -> after 5 cycles HI=1, LO=0; then MSUB A=1, B=1 -> HI=0, LO=0xFFFFFFFF.
